// File: rtl/hazard_unit_multicycle.sv
// Load-use / taken-branch hazard unit with multi-cycle stall and flush hold.
// Optional statistics counters are enabled by defining HAZARD_UNIT_STATS_EN.
module hazard_unit_multicycle #(
    parameter int REG_AW            = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_mem_read,
    input  logic              id_dest_valid,
    input  logic [REG_AW-1:0] id_dest_reg,
    input  logic [REG_AW-1:0] if_src1,
    input  logic [REG_AW-1:0] if_src2,
    input  logic              if_src2_used,
    input  logic              ex_is_branch,
    input  logic [1:0]        ex_cond,
    input  logic              zero,
    input  logic              carry,
`ifdef HAZARD_UNIT_STATS_EN
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  load_hazards,
    output logic [CNT_W-1:0]  flush_events,
`endif
    output logic              stall,
    output logic              flush,
    output logic              pc_write_en,
    output logic              ifid_write_en
);

    // Out-of-range hold lengths are clamped rather than rejected.
    localparam int L_C = (LOAD_STALL_CYCLES < 1) ? 1 :
                         ((LOAD_STALL_CYCLES > 15) ? 15 : LOAD_STALL_CYCLES);
    localparam int F_C = (FLUSH_CYCLES < 1) ? 1 :
                         ((FLUSH_CYCLES > 7) ? 7 : FLUSH_CYCLES);
    localparam logic [3:0] L_RELOAD = 4'(L_C - 1);
    localparam logic [3:0] F_RELOAD = 4'(F_C - 1);

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_FLUSH} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_load_use;
    logic w_cond_true;
    logic w_taken;
    logic w_stall;
    logic w_flush;

    always_comb begin
        w_cond_true = 1'b0;
        case (ex_cond)
            2'b00: w_cond_true = zero;
            2'b01: w_cond_true = ~zero;
            2'b10: w_cond_true = carry;
            2'b11: w_cond_true = ~carry;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_load_use = id_mem_read & id_dest_valid & (id_dest_reg != '0) &
                        ((id_dest_reg == if_src1) |
                         (if_src2_used & (id_dest_reg == if_src2)));
    assign w_taken    = ex_is_branch & w_cond_true;

    // Outputs are gated by rst so detection cannot leak through while held in reset.
    assign w_stall = rst & ~w_taken &
                     ((r_state == S_STALL) | ((r_state == S_IDLE) & w_load_use));
    assign w_flush = rst & (w_taken | (r_state == S_FLUSH));

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign pc_write_en   = ~w_stall;
    assign ifid_write_en = ~w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else if (w_taken) begin
            if (F_C > 1) begin
                r_state <= S_FLUSH;
                r_cnt   <= F_RELOAD;
            end else begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_use && (L_C > 1)) begin
                        r_state <= S_STALL;
                        r_cnt   <= L_RELOAD;
                    end
                end
                S_STALL, S_FLUSH: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_UNIT_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_load_hazards;
    logic [CNT_W-1:0] r_flush_events;

    // All counters saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_load_hazards <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_stall && (r_state == S_IDLE) && (r_load_hazards != '1))
                r_load_hazards <= r_load_hazards + 1'b1;
            if (w_taken && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign load_hazards = r_load_hazards;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: doc/hazard_unit_multicycle.md
Name: hazard_unit_multicycle

Overview:
Parametrised successor to the single-cycle hazard detector for the 19-bit MIPS-style pipeline.
- Detects load-use hazards between the ID stage (load in flight) and the IF stage (consumer), and taken conditional branches resolved in EX.
- Holds stall for a programmable number of cycles to cover longer memory latency, and holds flush for a programmable number of cycles to cover a deeper fetch front-end.
- Sits beside the pipeline registers and drives PC write-enable, IF/ID write-enable, ID/EX bubble and the flush line.

Parameters:
REG_AW, 3, register-address width
LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard (legal 1..15)
FLUSH_CYCLES, 1, flush cycles per taken branch (legal 1..7)
CNT_W, 16, width of the statistics counters (used only with the optional feature)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low
id_mem_read  in  1  ID instruction is a load
id_dest_valid  in  1  ID instruction writes a register
id_dest_reg  in  REG_AW  ID destination register
if_src1  in  REG_AW  IF source register 1 (always read)
if_src2  in  REG_AW  IF source register 2
if_src2_used  in  1  IF instruction reads src2
ex_is_branch  in  1  EX holds a conditional branch
ex_cond  in  2  branch condition: 00=Z, 01=!Z, 10=C, 11=!C
zero  in  1  ALU zero flag for the EX branch
carry  in  1  ALU carry flag for the EX branch
stall  out  1  freeze PC and IF/ID, bubble ID/EX
flush  out  1  squash IF/ID and ID/EX contents
pc_write_en  out  1  equals ~stall
ifid_write_en  out  1  equals ~stall

Behaviour:
- Hazard conditions:
  - load_use = id_mem_read & id_dest_valid & (id_dest_reg != 0) & ((id_dest_reg == if_src1) | (if_src2_used & id_dest_reg == if_src2)).
  - Register 0 never causes a hazard.
  - taken = ex_is_branch & the condition selected by ex_cond is true.
- State machine: IDLE, STALL, FLUSH, with a 4-bit down-counter cnt.
- Outputs are Mealy; detection affects the outputs in the same cycle with zero latency.
- IDLE:
  - If taken: flush=1, stall=0. Go to FLUSH with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else stay in IDLE.
  - Else if load_use: stall=1. Go to STALL with cnt=LOAD_STALL_CYCLES-1 if LOAD_STALL_CYCLES>1, else stay in IDLE.
  - Else: stall=0, flush=0.
- STALL:
  - stall=1 and flush=0. load_use is not re-evaluated.
  - cnt decrements each cycle; when cnt==1, the next state is IDLE, where load_use is re-evaluated.
  - If taken occurs in STALL: flush=1 and stall=0 that cycle, the stall count is abandoned, and the unit takes the IDLE taken transition.
- FLUSH:
  - flush=1, stall=0, and load_use is ignored.
  - cnt decrements; when cnt==1, the next state is IDLE.
  - A new taken in FLUSH reloads cnt=FLUSH_CYCLES-1, or returns to IDLE if FLUSH_CYCLES==1.
- Priority: taken overrides load_use in every state; stall and flush are never both 1.
- Reset:
  - rst low forces state=IDLE and cnt=0 immediately, asynchronously.
  - While rst is low: stall=0, flush=0, pc_write_en=1, ifid_write_en=1.
  - Reset mid-stall or mid-flush abandons the countdown; after release the unit evaluates from IDLE.
- Out-of-range parameters are a configuration error; the RTL clamps them to legal range via localparams.

Optional Feature:
Macro HAZARD_UNIT_STATS_EN.
- When defined, adds the following outputs, each cleared by rst:
  - stall_cycles [CNT_W-1:0]: increments every cycle stall=1.
  - load_hazards [CNT_W-1:0]: increments on each IDLE-to-stall detection.
  - flush_events [CNT_W-1:0]: increments on each taken.
- All three counters saturate at all-ones; they do not wrap.
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- L=1: id_mem_read=1, id_dest_valid=1, id_dest_reg=3, if_src1=3 for one cycle -> stall=1 and pc_write_en=0 that cycle only; next cycle with inputs cleared -> stall=0.
- L=3, same load-use condition held 1 cycle -> stall=1 for exactly 3 consecutive cycles, then 0. With id_dest_reg=0 instead -> stall never asserts.
- if_src2=5, id_dest_reg=5, if_src2_used=0 -> no stall; if_src2_used=1 -> stall.
- F=2: ex_is_branch=1 with each ex_cond/flag pair (00/Z=1, 01/Z=0, 10/C=1, 11/C=0) -> flush=1 for 2 cycles. Each inverse flag value -> flush stays 0.
- L=3, taken arrives in the 2nd stall cycle -> that cycle stall=0 and flush=1; stall does not resume. Simultaneous load_use and taken in IDLE -> flush only.
- rst pulsed low mid-STALL (L=3) -> stall drops asynchronously; after release, stall stays 0 with idle inputs. With HAZARD_UNIT_STATS_EN defined -> counters read 0 after reset and saturate at 2^CNT_W-1 (checked with CNT_W=4).
